// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit indices and FSM states shared by alu_pipe and its bench
package alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam int F_ZERO  = 0;
  localparam int F_NEG   = 1;
  localparam int F_CARRY = 2;
  localparam int F_OVF   = 3;
  localparam int F_ILL   = 4;
  typedef enum logic {IDLE, BUSY} state_e;
endpackage

// File: rtl/mul_iter.sv
// mul_iter: shift-add multiplier, start loads a/b, done flags the WIDTH-th edge on which p is the low WIDTH bits of a*b
module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] p
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] mc_q, mp_q, acc_q;
  logic [CW-1:0] cnt_q;
  logic run_q;
  assign done = run_q && cnt_q == CW'(WIDTH - 1);
  assign p = acc_q + (mp_q[0] ? mc_q : '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_q  <= '0;
      mp_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      mc_q  <= a;
      mp_q  <= b;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      mc_q  <= mc_q << 1;
      mp_q  <= mp_q >> 1;
      acc_q <= p;
      cnt_q <= cnt_q + CW'(1);
      run_q <= !done;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: single-cycle ALU plus iterative MUL with valid/ready in and out, registered result and {ill,ovf,carry,neg,zero} flags
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);
  localparam int SW = $clog2(WIDTH);
  state_e state_q, state_d;
  logic ov_q, ov_d;
  logic [WIDTH-1:0] res_q, res_d, alu_r, prod, bb;
  logic [4:0] flg_q, flg_d, alu_f;
  logic [WIDTH:0] sum;
  logic [SW-1:0] sh;
  logic sub, arith, accept, mul_start, mul_done;
  assign in_ready = state_q == IDLE && (!ov_q || out_ready);
  assign accept = in_valid && in_ready;
  assign mul_start = accept && op == OP_MUL;
  assign sub = op == OP_SUB;
  assign arith = op == OP_ADD || sub;
  assign bb = sub ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, bb} + (WIDTH + 1)'(sub);
  assign sh = b[SW-1:0];
  always_comb begin
    alu_r = '0;
    case (op)
      OP_ADD, OP_SUB: alu_r = sum[WIDTH-1:0];
      OP_AND:  alu_r = a & b;
      OP_OR:   alu_r = a | b;
      OP_XOR:  alu_r = a ^ b;
      OP_SLT:  alu_r = {{(WIDTH - 1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_r = {{(WIDTH - 1){1'b0}}, a < b};
      OP_SLL:  alu_r = a << sh;
      OP_SRL:  alu_r = a >> sh;
      OP_SRA:  alu_r = $signed(a) >>> sh;
      default: alu_r = '0;
    endcase
    alu_f = '0;
    alu_f[F_CARRY] = arith && sum[WIDTH];
    alu_f[F_OVF] = arith && a[WIDTH-1] == bb[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
    alu_f[F_NEG] = alu_r[WIDTH-1];
    alu_f[F_ZERO] = alu_r == '0;
    alu_f[F_ILL] = op > OP_MUL;
  end
  always_comb begin
    state_d = mul_done ? IDLE : mul_start ? BUSY : state_q;
    ov_d = mul_done || (accept && !mul_start) || (ov_q && !out_ready);
    res_d = mul_done ? prod : (accept && !mul_start) ? alu_r : res_q;
    flg_d = mul_done ? {3'b000, prod[WIDTH-1], prod == '0} : (accept && !mul_start) ? alu_f : flg_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ov_q    <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      ov_q    <= ov_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end
  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .p     (prod)
  );
  assign out_valid = ov_q;
  assign result = res_q;
  assign flags = flg_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed corner cases plus random traffic scored against an arithmetic reference model
module tb_alu_pipe;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [31:0] a = '0, b = '0, result;
  logic [3:0] op = '0;
  logic [4:0] flags;
  int n_tests = 0, n_fail = 0;
  logic [36:0] sb[$];
  always #5 clk = ~clk;
  alu_pipe #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [36:0] model(input logic [31:0] x, input logic [31:0] y, input logic [3:0] o);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    int sh = int'(y[4:0]);
    logic [63:0] u;
    logic [31:0] r = '0;
    logic c = 1'b0, v = 1'b0, ill = 1'b0;
    case (o)
      4'd0: begin u = {32'b0, x} + {32'b0, y}; r = u[31:0]; c = u[32]; v = (sx + sy) != longint'($signed(r)); end
      4'd1: begin u = {32'b0, x} + {32'b0, ~y} + 64'd1; r = u[31:0]; c = u[32]; v = (sx - sy) != longint'($signed(r)); end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = {31'b0, sx < sy};
      4'd6: r = {31'b0, x < y};
      4'd7: r = x << sh;
      4'd8: r = x >> sh;
      4'd9: begin u = sx >>> sh; r = u[31:0]; end
      4'd10: begin u = {32'b0, x} * {32'b0, y}; r = u[31:0]; end
      default: ill = 1'b1;
    endcase
    return {ill, v, c, r[31], r == 32'd0, r};
  endfunction
  task automatic cyc(input logic v, input logic [31:0] ai, input logic [31:0] bi, input logic [3:0] oi, input logic rdy);
    logic acc, dlv, hold;
    logic [36:0] obs, e;
    in_valid = v; a = ai; b = bi; op = oi; out_ready = rdy;
    @(negedge clk);
    acc = v && in_ready && rst_n;
    dlv = out_valid && rdy && rst_n;
    hold = out_valid && !rdy && rst_n;
    obs = {flags, result};
    @(posedge clk);
    #1;
    if (!rst_n) return;
    if (dlv) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_result", 64'(obs), 64'(e));
      end
    end
    if (hold) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", 64'({flags, result}), 64'(obs));
    end
    if (acc) sb.push_back(model(ai, bi, oi));
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    logic busy_rdy;
    logic [3:0] o;
    repeat (3) cyc(1'b1, $urandom, $urandom, 4'd0, 1'b1);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 32'hFFFF_FFFF, 32'd1, 4'd0, 1'b1);
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_res", 64'(result), 64'd0);
    check("add_flags", 64'(flags), 64'b00101);
    cyc(1'b1, 32'h8000_0000, 32'd1, 4'd1, 1'b1);
    check("sub_res", 64'(result), 64'h7FFF_FFFF);
    check("sub_flags", 64'(flags), 64'b01100);
    cyc(1'b1, 32'h8000_0000, 32'h24, 4'd9, 1'b1);
    check("sra_res", 64'(result), 64'hF800_0000);
    cyc(1'b1, 32'd1, 32'hFFFF_FFFF, 4'd6, 1'b1);
    check("sltu_res", 64'(result), 64'd1);
    cyc(1'b1, 32'd1, 32'hFFFF_FFFF, 4'd5, 1'b1);
    check("slt_res", 64'(result), 64'd0);
    cyc(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
    check("drain_valid", 64'(out_valid), 64'd0);
    cyc(1'b1, 32'h0001_0003, 32'd5, 4'd10, 1'b0);
    n = 1;
    busy_rdy = 1'b0;
    while (!out_valid && n < 40) begin
      busy_rdy |= in_ready;
      cyc(1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)), 1'b0);
      n++;
    end
    check("mul_latency", 64'(n), 64'd33);
    check("mul_busy_ready", 64'(busy_rdy), 64'd0);
    check("mul_res", 64'(result), 64'h0005_000F);
    cyc(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
    cyc(1'b1, 32'd7, 32'd8, 4'd0, 1'b0);
    cyc(1'b1, 32'hF0F0, 32'h0FF0, 4'd4, 1'b0);
    check("bp_add_res", 64'(result), 64'd15);
    check("bp_xor_blocked", 64'(sb.size()), 64'd1);
    cyc(1'b1, 32'hF0F0, 32'h0FF0, 4'd4, 1'b1);
    check("bp_xor_res", 64'(result), 64'hFF00);
    check("bp_xor_queued", 64'(sb.size()), 64'd1);
    cyc(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
    cyc(1'b1, 32'h1234, 32'h5678, 4'd10, 1'b1);
    repeat (9) cyc(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_flags", 64'(flags), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    repeat (2) cyc(1'b1, 32'd2, 32'd3, 4'd0, 1'b1);
    check("rst_no_accept", 64'(out_valid), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 64'(in_ready), 64'd1);
    check("post_rst_valid", 64'(out_valid), 64'd0);
    cyc(1'b1, 32'd2, 32'd3, 4'd0, 1'b0);
    check("post_rst_add", 64'(result), 64'd5);
    cyc(1'b1, 32'd9, 32'd9, 4'd15, 1'b1);
    check("illegal_res", 64'(result), 64'd0);
    check("illegal_flags", 64'(flags), 64'b10001);
    cyc(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
    repeat (600) begin
      o = 4'($urandom_range(0, 15));
      if (o == 4'd10 && $urandom_range(0, 3) != 0) o = 4'd1;
      cyc($urandom_range(0, 3) != 0, pick(), pick(), o, $urandom_range(0, 3) != 0);
    end
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      cyc(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
      n++;
    end
    check("final_drain", 64'(sb.size()), 64'd0);
    check("final_valid", 64'(out_valid), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; SHALL be a power of two, 8 to 64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand/opcode presented.
REQ-005 in_ready  output  1  block accepts operation this cycle.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B; shift amount is b[log2(WIDTH)-1:0].
REQ-008 op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL; 11-15 illegal.
REQ-009 out_valid  output  1  result registers hold an undelivered result.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 result  output  WIDTH  registered result.
REQ-012 flags  output  5  registered {illegal, overflow, carry, negative, zero}.

Function
REQ-013 Accept occurs on an edge where in_valid && in_ready; in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-014 Ops 0-9: result and flags SHALL load on the accepting edge; out_valid high from that edge (latency 1).
REQ-015 MUL: accepting edge enters BUSY; WIDTH further edges of shift-add iteration; on the WIDTH-th, low WIDTH bits of a*b load into result, out_valid set, state returns to IDLE (latency WIDTH+1 edges).
REQ-016 FSM states IDLE, BUSY only; in_ready SHALL be 0 throughout BUSY.
REQ-017 AND/OR/XOR SHALL be bitwise across all WIDTH bits.
REQ-018 SUB SHALL compute a + ~b + 1; carry = carry-out of that sum (1 = no borrow).
REQ-019 ADD/SUB overflow = signed overflow of the WIDTH-bit result; other ops: carry=0, overflow=0.
REQ-020 SLT/SLTU result = {WIDTH-1 zeros, comparison bit}, signed / unsigned respectively.
REQ-021 SRA SHALL replicate a[WIDTH-1]; SLL/SRL fill zeros; shift amount 0 returns a.
REQ-022 zero = (result==0); negative = result[WIDTH-1]; both valid for every op.
REQ-023 Illegal op: accepted with latency 1, result=0, flags = illegal=1, zero=1, others 0.
REQ-024 While out_valid && !out_ready, result and flags SHALL remain stable.
REQ-025 out_valid clears on an edge with out_ready=1 unless a new op completes on the same edge (back-to-back throughput 1/cycle for ops 0-10 except MUL).
REQ-026 out_ready while out_valid=0 SHALL have no effect.
REQ-027 Inputs a, b, op are sampled only on the accepting edge; changes at other times are ignored, including during BUSY.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, out_valid=0, result=0, flags=0, iteration counter=0.
REQ-029 Reset during BUSY SHALL abort the multiply with no result delivered; in_ready=1 on first edge after release.
REQ-030 No operation SHALL be accepted while rst_n is low.

Structure
REQ-031 Package alu_pkg SHALL hold opcode constants, flag bit indices, and the state enumeration.
REQ-032 Iterative multiplier SHALL be sub-module mul_iter (start, done, WIDTH-parameterised); all other logic in alu_pipe.
REQ-033 Target 120-400 lines RTL total; no latches; single clock domain.

Verification (WIDTH=32)
REQ-034 ADD a=0xFFFFFFFF b=0x1 -> result 0x0, zero=1, carry=1, overflow=0, out_valid one edge after accept.
REQ-035 SUB a=0x80000000 b=0x1 -> result 0x7FFFFFFF, overflow=1, carry=1, negative=0.
REQ-036 SRA a=0x80000000 b=0x24 -> result 0xF8000000 (shamt 4); SLTU a=1 b=0xFFFFFFFF -> 0x1; SLT same operands -> 0x0.
REQ-037 MUL a=0x00010003 b=0x5 -> result 0x0005000F, out_valid exactly 33 edges after accept, in_ready=0 for those intervening cycles.
REQ-038 out_ready=0, issue ADD then XOR -> XOR not accepted, ADD result stable; out_ready=1 -> ADD delivered, XOR accepted same edge.
REQ-039 rst_n low at BUSY cycle 10 of a MUL -> out_valid=0, no result; after release ADD 2+3 -> 0x5; op=15 -> result 0, illegal=1.
